irq_flags: RTL and testbench
============================

IRQ_FLAGS -- requirements
Module: irq_flags

Interface
REQ-001 SHALL have parameter NSRC, default 5, number of interrupt sources: VBlank, STAT, Timer, Serial, Joypad, in bit order 0..4.
REQ-002 SHALL have parameter IF_ADDR, default 16'hFF0F, bus address of the flag register.
REQ-003 CLK  input  1  single block clock; all state updates on rising edge.
REQ-004 nRESET  input  1  reset; synchronous, active-low.
REQ-005 IRQ_SRC  input  NSRC  level request lines from peripherals, synchronous to CLK.
REQ-006 A  input  16  core address bus.
REQ-007 D_IN  input  8  core write data.
REQ-008 D_OUT  output  8  read data.
REQ-009 D_OE  output  1  read-data drive enable.
REQ-010 RD  input  1  core read strobe.
REQ-011 WR  input  1  core write strobe, one CLK cycle per write.
REQ-012 CPU_IRQ_TRIG  output  8  pending flags to core.
REQ-013 CPU_IRQ_ACK  input  8  per-bit acknowledge from core.
REQ-014 WAKE  output  1  one-cycle pulse on new Joypad request.

Function
REQ-015 SHALL hold flag register IF[NSRC-1:0] and previous-sample register SRC_Q[NSRC-1:0].
REQ-016 SHALL detect edge[i] = IRQ_SRC[i] & ~SRC_Q[i]; SRC_Q <= IRQ_SRC every cycle.
REQ-017 SHALL compute sel = (A == IF_ADDR).
REQ-018 SHALL update every cycle: IF_next = ((WR & sel) ? D_IN[NSRC-1:0] : IF) & ~CPU_IRQ_ACK[NSRC-1:0] | edge.
REQ-019 Priority per bit, same cycle: edge set > ACK clear > bus write > hold.
REQ-020 Held ACK SHALL clear its bit every cycle it is high; a level-held source SHALL NOT re-set the bit (edge only).
REQ-021 CPU_IRQ_TRIG SHALL equal {(8-NSRC) zeros, IF}, registered; one-cycle latency from edge to TRIG.
REQ-022 CPU_IRQ_ACK bits above NSRC-1 SHALL be ignored.
REQ-023 Read: D_OE = RD & sel & ~WR, combinational; D_OUT = {(8-NSRC) ones, IF} when D_OE, else 8'h00.
REQ-024 Read and edge in the same cycle SHALL return the pre-update IF; the new bit is visible next cycle.
REQ-025 Write with A != IF_ADDR SHALL have no effect; RD and WR both high SHALL perform the write and keep D_OE low.
REQ-026 WAKE SHALL be registered high for exactly one cycle after a cycle with edge[4], independent of IF.

Reset
REQ-027 While nRESET is low at a CLK edge: IF=0, SRC_Q=IRQ_SRC, CPU_IRQ_TRIG=8'h00, WAKE=0.
REQ-028 Sampling SRC_Q from the live IRQ_SRC at reset SHALL suppress spurious edges for sources already high when reset is released.
REQ-029 Reset asserted mid-operation SHALL discard pending flags and in-flight writes in that cycle.

Structure
REQ-030 A shared package SHALL hold IF_ADDR default, NSRC default, and source bit-index constants (IRQ_VBLANK..IRQ_JOYPAD).
REQ-031 Sub-module irq_edge_det (per-source edge detector with reset preload) SHALL be instantiated NSRC times.
REQ-032 The block SHALL drive no inout; top-level merges D_OUT/D_OE onto the core data bus.

Verification
REQ-033 Reset with IRQ_SRC=5'b00001 held, release, hold 10 cycles -> IF=0, TRIG=8'h00 throughout.
REQ-034 Pulse IRQ_SRC[2] 0->1 at cycle n -> TRIG=8'h04 from n+1; read FF0F -> D_OUT=8'hE4; ACK=8'h04 one cycle -> TRIG=8'h00 next cycle.
REQ-035 Same-cycle edge on bit 0 and ACK bit 0 -> IF[0]=1 after the cycle; ACK again alone -> IF[0]=0.
REQ-036 WR at FF0F with D_IN=8'hFF -> TRIG=8'h1F; same-cycle ACK=8'h01 -> TRIG=8'h1E; WR at FF0E -> no change.
REQ-037 Rising edge on IRQ_SRC[4] -> WAKE high exactly one cycle, TRIG=8'h10; IRQ_SRC[4] held high 20 cycles after ACK -> no re-set.
REQ-038 nRESET low mid-stream with IF=5'h1B -> TRIG=8'h00 next cycle; random edge/ACK/WR stress checked against REQ-018 model.

Source files
------------

// File: rtl/irq_flags_pkg.sv
// Shared definitions for the interrupt flag block.
//   NSRC_DEFAULT    : number of interrupt sources
//   IF_ADDR_DEFAULT : bus address of the flag register
//   IRQ_*           : bit index of each source inside the flag register
package irq_flags_pkg;

  localparam int          NSRC_DEFAULT    = 5;
  localparam logic [15:0] IF_ADDR_DEFAULT = 16'hFF0F;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

endpackage

// File: rtl/irq_edge_det.sv
// Rising-edge detector for one interrupt request line.
//   CLK    : block clock
//   nRESET : synchronous active-low reset
//   i_src  : level request from a peripheral
//   o_edge : high in the cycle where i_src is high and was low last cycle
module irq_edge_det (
  input  logic CLK,
  input  logic nRESET,
  input  logic i_src,
  output logic o_edge
);

  logic r_q;

  // During reset the previous-sample register is preloaded from the live
  // line, so a source that is already high at reset release never looks
  // like a fresh edge. Outside reset it simply tracks the line.
  always_ff @(posedge CLK) begin
    if (!nRESET) r_q <= i_src;
    else         r_q <= i_src;
  end

  assign o_edge = i_src & ~r_q;

endmodule

// File: rtl/irq_flags.sv
// Interrupt flag register with edge-triggered set, per-bit acknowledge
// clear and a bus-mapped read/write port.
//   CLK, nRESET  : clock, synchronous active-low reset
//   IRQ_SRC      : level request lines from peripherals
//   A, D_IN      : core address and write data
//   RD, WR       : core read/write strobes
//   D_OUT, D_OE  : read data and its drive enable (merged onto the bus above)
//   CPU_IRQ_TRIG : pending flags, zero-extended to 8 bits
//   CPU_IRQ_ACK  : per-bit acknowledge from the core
//   WAKE         : one-cycle pulse after a new Joypad request
module irq_flags
  import irq_flags_pkg::*;
#(
  parameter int          NSRC    = NSRC_DEFAULT,
  parameter logic [15:0] IF_ADDR = IF_ADDR_DEFAULT
) (
  input  logic            CLK,
  input  logic            nRESET,
  input  logic [NSRC-1:0] IRQ_SRC,
  input  logic [15:0]     A,
  input  logic [7:0]      D_IN,
  output logic [7:0]      D_OUT,
  output logic            D_OE,
  input  logic            RD,
  input  logic            WR,
  output logic [7:0]      CPU_IRQ_TRIG,
  input  logic [7:0]      CPU_IRQ_ACK,
  output logic            WAKE
);

  // Unimplemented flag bits read back as ones.
  localparam logic [7:0] READ_PAD = 8'hFF << NSRC;

  logic [NSRC-1:0] r_if;
  logic            r_wake;
  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_if_next;
  logic            w_sel;
  logic            w_joy_edge;
  logic            w_unused_hi;

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_edge
      irq_edge_det u_edge_det (
        .CLK    (CLK),
        .nRESET (nRESET),
        .i_src  (IRQ_SRC[g]),
        .o_edge (w_edge[g])
      );
    end
    if (NSRC > IRQ_JOYPAD) begin : g_joy
      assign w_joy_edge = w_edge[IRQ_JOYPAD];
    end else begin : g_no_joy
      assign w_joy_edge = 1'b0;
    end
  endgenerate

  assign w_sel = (A == IF_ADDR);

  // Per bit: a new edge beats an acknowledge, which beats a bus write.
  always_comb begin
    w_if_next = ((WR & w_sel) ? D_IN[NSRC-1:0] : r_if) & ~CPU_IRQ_ACK[NSRC-1:0];
    w_if_next = w_if_next | w_edge;
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_if   <= '0;
      r_wake <= 1'b0;
    end else begin
      r_if   <= w_if_next;
      r_wake <= w_joy_edge;
    end
  end

  assign CPU_IRQ_TRIG = 8'(r_if);
  assign WAKE         = r_wake;

  // A write wins over a simultaneous read, so the bus is not driven then.
  assign D_OE  = RD & w_sel & ~WR;
  assign D_OUT = D_OE ? (READ_PAD | 8'(r_if)) : 8'h00;

  // Data and acknowledge bits above the implemented sources are ignored.
  assign w_unused_hi = &{1'b0, D_IN, CPU_IRQ_ACK};

endmodule

// File: tb/tb_irq_flags.sv
module tb_irq_flags;

  localparam logic [15:0] F = 16'hFF0F;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic [4:0]  IRQ_SRC;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic        RD;
  logic        WR;
  logic [7:0]  CPU_IRQ_TRIG;
  logic [7:0]  CPU_IRQ_ACK;
  logic        WAKE;

  irq_flags dut (
    .CLK          (CLK),
    .nRESET       (nRESET),
    .IRQ_SRC      (IRQ_SRC),
    .A            (A),
    .D_IN         (D_IN),
    .D_OUT        (D_OUT),
    .D_OE         (D_OE),
    .RD           (RD),
    .WR           (WR),
    .CPU_IRQ_TRIG (CPU_IRQ_TRIG),
    .CPU_IRQ_ACK  (CPU_IRQ_ACK),
    .WAKE         (WAKE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  src;
    logic [15:0] a;
    logic [7:0]  din;
    logic        rd;
    logic        wr;
    logic [7:0]  ack;
    logic        rstn;
    logic [7:0]  exp_trig;
    logic        exp_wake;
    logic        exp_oe;
    logic [7:0]  exp_dout;
  } vec_t;

  typedef struct {
    logic [7:0] trig;
    logic       wake;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  logic [4:0] m_if;
  logic [4:0] m_q;
  bit         m_valid = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: drive, check combinational read port, push the expected
  // post-edge state, clock, then pop and compare.
  task automatic apply(input vec_t v, input bit from_tab);
    logic       sel, e_oe, e_wake;
    logic [7:0] e_dout;
    logic [4:0] nxt;
    exp_t       e;
    IRQ_SRC = v.src; A = v.a; D_IN = v.din; RD = v.rd; WR = v.wr;
    CPU_IRQ_ACK = v.ack; nRESET = v.rstn;

    sel    = (v.a == F);
    e_oe   = v.rd & sel & ~v.wr;
    e_dout = e_oe ? {3'b111, m_if} : 8'h00;
    if (!v.rstn) begin
      nxt    = '0;
      e_wake = 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (v.src[i] && !m_q[i])  nxt[i] = 1'b1;
        else if (v.ack[i])        nxt[i] = 1'b0;
        else if (v.wr && sel)     nxt[i] = v.din[i];
        else                      nxt[i] = m_if[i];
      end
      e_wake = v.src[4] & ~m_q[4];
    end
    if (from_tab) begin
      e_oe = v.exp_oe; e_dout = v.exp_dout;
      e.trig = v.exp_trig; e.wake = v.exp_wake;
    end else begin
      e.trig = {3'b000, nxt}; e.wake = e_wake;
    end

    #1;
    if (m_valid) begin
      check8("d_oe", {7'd0, D_OE}, {7'd0, e_oe});
      check8("d_out", D_OUT, e_dout);
    end
    sb_q.push_back(e);

    m_if = nxt;
    m_q  = v.src;
    if (!v.rstn) m_valid = 1;

    @(posedge CLK); #1;
    e = sb_q.pop_front();
    check8("trig", CPU_IRQ_TRIG, e.trig);
    check8("wake", {7'd0, WAKE}, {7'd0, e.wake});
  endtask

  function automatic vec_t mk(input logic [4:0] src, input logic [15:0] a, input logic [7:0] din,
                              input logic rd, input logic wr, input logic [7:0] ack, input logic rstn,
                              input logic [7:0] et, input logic ew, input logic eo, input logic [7:0] ed);
    vec_t v;
    v.src = src; v.a = a; v.din = din; v.rd = rd; v.wr = wr; v.ack = ack; v.rstn = rstn;
    v.exp_trig = et; v.exp_wake = ew; v.exp_oe = eo; v.exp_dout = ed;
    return v;
  endfunction

  vec_t tab[18];

  initial begin
    //           src       a        din    rd wr ack    rst trig  wk oe dout
    tab[0]  = mk(5'b00101, 16'h0,   8'h00, 0, 0, 8'h00, 1, 8'h04, 0, 0, 8'h00);
    tab[1]  = mk(5'b00101, F,       8'h00, 1, 0, 8'h00, 1, 8'h04, 0, 1, 8'hE4);
    tab[2]  = mk(5'b00101, 16'h0,   8'h00, 0, 0, 8'h04, 1, 8'h00, 0, 0, 8'h00);
    tab[3]  = mk(5'b00101, 16'h0,   8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    tab[4]  = mk(5'b00100, 16'h0,   8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    tab[5]  = mk(5'b00101, 16'h0,   8'h00, 0, 0, 8'h01, 1, 8'h01, 0, 0, 8'h00);
    tab[6]  = mk(5'b00101, 16'h0,   8'h00, 0, 0, 8'h01, 1, 8'h00, 0, 0, 8'h00);
    tab[7]  = mk(5'b00101, F,       8'hFF, 0, 1, 8'h00, 1, 8'h1F, 0, 0, 8'h00);
    tab[8]  = mk(5'b00101, F,       8'hFF, 0, 1, 8'h01, 1, 8'h1E, 0, 0, 8'h00);
    tab[9]  = mk(5'b00101, 16'hFF0E,8'h00, 0, 1, 8'h00, 1, 8'h1E, 0, 0, 8'h00);
    tab[10] = mk(5'b00101, F,       8'h03, 1, 1, 8'h00, 1, 8'h03, 0, 0, 8'h00);
    tab[11] = mk(5'b00101, 16'hFF0E,8'h00, 1, 0, 8'h00, 1, 8'h03, 0, 0, 8'h00);
    tab[12] = mk(5'b10101, F,       8'h00, 1, 0, 8'h00, 1, 8'h13, 1, 1, 8'hE3);
    tab[13] = mk(5'b10101, 16'h0,   8'h00, 0, 0, 8'h00, 1, 8'h13, 0, 0, 8'h00);
    tab[14] = mk(5'b10101, 16'h0,   8'h00, 0, 0, 8'h10, 1, 8'h03, 0, 0, 8'h00);
    tab[15] = mk(5'b10101, F,       8'h1B, 0, 1, 8'h00, 1, 8'h1B, 0, 0, 8'h00);
    tab[16] = mk(5'b11111, F,       8'hFF, 0, 1, 8'h00, 0, 8'h00, 0, 0, 8'h00);
    tab[17] = mk(5'b11111, 16'h0,   8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);

    m_if = '0; m_q = '0;

    // Reset with VBlank already high, then hold: no spurious flag.
    apply(mk(5'b00001, 16'h0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00), 1);
    apply(mk(5'b00001, 16'h0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00), 1);
    for (int i = 0; i < 10; i++)
      apply(mk(5'b00001, 16'h0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00), 1);

    for (int i = 0; i < 18; i++) apply(tab[i], 1);

    // Joypad edge after reset release, then ack and a long level hold.
    apply(mk(5'b01111, 16'h0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00), 1);
    apply(mk(5'b11111, 16'h0, 8'h00, 0, 0, 8'h00, 1, 8'h10, 1, 0, 8'h00), 1);
    apply(mk(5'b11111, F,     8'h00, 1, 0, 8'h10, 1, 8'h00, 0, 1, 8'hF0), 1);
    for (int i = 0; i < 20; i++)
      apply(mk(5'b11111, 16'h0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00), 1);

    // Random stress against the reference model.
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      int   ac;
      v = mk(5'($urandom), 16'h0, 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             8'h00, ($urandom_range(0, 39) != 0), 8'h00, 0, 0, 8'h00);
      ac = $urandom_range(0, 3);
      v.a = (ac < 2) ? F : (ac == 2) ? 16'hFF0E : 16'($urandom);
      if ($urandom_range(0, 2) == 0) v.ack = 8'($urandom);
      apply(v, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
